truth_table_sequencer: RTL
==========================

# truth_table_sequencer

Controller that exercises the three-input combinational function block (F = ~((A & B) | (~B & C))) by sweeping all eight input vectors, capturing F for each into an 8-bit truth-table register, and optionally self-checking the result against a golden mask. Sits between the board-level start button/LEDs and the function block. It drives A/B/C and reads F back, so the lab design can be demonstrated and checked in hardware without manual switch toggling.

## Interface
- SETTLE_CYCLES, 2: cycles each vector is held before F is sampled; legal range 1–15.
- EXPECTED, 8'h1D: golden truth table; bit i is the required F for {A,B,C} = i.

- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  level; sampled only in IDLE; begins a sweep.
- drv_a  output  1  A input of the function block (MSB of vector index).
- drv_b  output  1  B input of the function block.
- drv_c  output  1  C input of the function block (LSB of vector index).
- f_in  input  1  F output of the function block.
- busy  output  1  high from sweep start until the DONE cycle, exclusive.
- done  output  1  one-cycle pulse at sweep completion.
- table_out  output  8  captured truth table; bit i = F sampled for vector i.
- pass  output  1  table_out == EXPECTED; valid from done until next accepted start.
- err_count  output  4  number of mismatching bits (0–8); same validity as pass.

## Operation
- States: IDLE, DRIVE, SAMPLE, DONE. Internal 3-bit vector index idx, 4-bit settle counter.
- IDLE: drv_* = 0. busy = 0. On start = 1:
  - idx ← 0, counter ← 0.
  - table_out ← 0, pass ← 0, err_count ← 0.
  - → DRIVE.
- DRIVE: {drv_a, drv_b, drv_c} = idx, registered and stable for the whole vector. Counter increments each cycle. When counter reaches SETTLE_CYCLES−1 → SAMPLE.
- SAMPLE: drive is unchanged. At the clock edge, table_out[idx] ← f_in and counter ← 0.
  - If idx < 7: idx ← idx+1, → DRIVE.
  - If idx = 7: → DONE.
- DONE: done = 1, busy = 0, drv_* hold vector 7. Self-check results are updated at entry to DONE. → IDLE unconditionally on the next edge.
- start is ignored in DRIVE, SAMPLE and DONE. There is no queuing. A start held high through DONE begins a new sweep from IDLE one cycle later.
- table_out, pass and err_count hold their values in IDLE until the next accepted start.
- Reset at any point:
  - State → IDLE.
  - All outputs → 0: drv_a/b/c, busy, done, table_out, pass, err_count.
  - idx and counter → 0.
  - The partial sweep is discarded.
- err_count = popcount(table_out ^ EXPECTED), 4-bit unsigned, maximum 8, no wrap.

## Timing
- Reset values: every output is 0.
- start sampled high at edge E0:
  - Vector 0 appears on drv_* and busy = 1 from E0.
  - Vector i is driven from edge E0 + i·(SETTLE_CYCLES+1).
  - f_in for vector i is captured at edge E0 + (i+1)·(SETTLE_CYCLES+1).
- done is high for exactly the cycle following edge E0 + 8·(SETTLE_CYCLES+1). With the default, that is 24 cycles after E0.
- Earliest next accepted start: the edge ending the cycle after done. Back-to-back sweeps are separated by one IDLE cycle.
- f_in is treated as combinational from drv_*. The settle window guarantees at least SETTLE_CYCLES cycles of stable input before capture.

## Configuration
- TT_SELFCHECK_EN:
  - Defined: the comparator and popcount logic are compiled in. pass and err_count behave as specified above.
  - Undefined: comparator and popcount are removed. pass and err_count are tied to 0. The EXPECTED parameter is unused. Sweep, table_out, busy and done timing are identical either way.

## Test plan
- Reset, then a correct function block, TT_SELFCHECK_EN defined, SETTLE_CYCLES=2, start pulse: done occurs 24 cycles after start; table_out = 8'h1D, pass = 1, err_count = 0.
- Function block replaced by stuck-at-1 F: table_out = 8'hFF, pass = 0, err_count = 4.
- start held high continuously: sweeps repeat. The second sweep's vector 0 is driven 2 cycles after the first done. table_out is cleared to 0 at the second accept.
- reset asserted during vector 4's DRIVE: the next cycle all outputs are 0 and the state is IDLE. A subsequent start produces a full, correct 8'h1D sweep.
- start pulses during busy are ignored: done timing is unchanged and exactly one done pulse occurs.
- TT_SELFCHECK_EN undefined, correct block: table_out = 8'h1D, pass = 0, err_count = 0, done timing unchanged.

Source files
------------

// File: rtl/truth_table_sequencer_if.sv
// Signal bundle between the truth-table sequencer (master) and the board buttons/LEDs
// plus the function block under test (slave side).
interface truth_table_sequencer_if;
   logic       start;
   logic       drv_a;
   logic       drv_b;
   logic       drv_c;
   logic       f_in;
   logic       busy;
   logic       done;
   logic [7:0] table_out;
   logic       pass;
   logic [3:0] err_count;

   modport master (
      input  start, f_in,
      output drv_a, drv_b, drv_c, busy, done, table_out, pass, err_count
   );

   modport slave (
      output start, f_in,
      input  drv_a, drv_b, drv_c, busy, done, table_out, pass, err_count
   );
endinterface

// File: rtl/truth_table_sequencer.sv
// Sweeps all eight {A,B,C} vectors through the function block and captures F into a truth table.
// Define TT_SELFCHECK_EN to compile in the golden-mask comparator (pass / err_count).
module truth_table_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter logic [7:0]  EXPECTED      = 8'h1D
) (
   input logic                     clk,
   input logic                     reset,
   truth_table_sequencer_if.master bus
);

   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15 || $bits(EXPECTED) != 8) begin : g_bad_cfg
      $error("truth_table_sequencer: SETTLE_CYCLES must be 1..15");
   end

   state_t     state_q;
   state_t     state_d;
   logic [2:0] idx_q;
   logic [3:0] cnt_q;
   logic [7:0] table_q;
   logic [7:0] table_next;
   logic       accept;
   logic       last_capture;

   assign accept       = (state_q == IDLE) && bus.start;
   assign last_capture = (state_q == SAMPLE) && (idx_q == 3'd7);

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // NOTE: next-state defaults to the current state first, so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.start) state_d = DRIVE;
         DRIVE:   if (cnt_q == SETTLE_LAST) state_d = SAMPLE;
         SAMPLE:  state_d = (idx_q == 3'd7) ? DONE : DRIVE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      table_next        = table_q;
      table_next[idx_q] = bus.f_in;
   end

   // idx doubles as the registered drive vector; clearing it on the way out of DONE parks drv_* at 0.
   // NOTE: the 8-bit table is a plain register, not a memory, so it is reset along with the rest.
   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q   <= '0;
         cnt_q   <= '0;
         table_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  idx_q   <= '0;
                  cnt_q   <= '0;
                  table_q <= '0;
               end
            end
            DRIVE:  cnt_q <= cnt_q + 4'd1;
            SAMPLE: begin
               table_q <= table_next;
               cnt_q   <= '0;
               if (idx_q != 3'd7) idx_q <= idx_q + 3'd1;
            end
            DONE:    idx_q <= '0;
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.busy      = (state_q == DRIVE) || (state_q == SAMPLE);
      bus.done      = (state_q == DONE);
      bus.drv_a     = idx_q[2];
      bus.drv_b     = idx_q[1];
      bus.drv_c     = idx_q[0];
      bus.table_out = table_q;
   end

`ifdef TT_SELFCHECK_EN
   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) n = n + 4'(v[i]);
      return n;
   endfunction

   logic       pass_q;
   logic [3:0] err_q;

   // Results are computed from the table as it will be after the final capture edge.
   always_ff @(posedge clk) begin
      if (reset || accept) begin
         pass_q <= 1'b0;
         err_q  <= '0;
      end else if (last_capture) begin
         pass_q <= (table_next == EXPECTED);
         err_q  <= popcount8(table_next ^ EXPECTED);
      end
   end

   assign bus.pass      = pass_q;
   assign bus.err_count = err_q;
`else
   logic unused_last_capture;
   assign unused_last_capture = last_capture;
   assign bus.pass            = 1'b0;
   assign bus.err_count       = 4'd0;
`endif

endmodule
